// File: rtl/pq_req_sched_if.sv
// Requester-side command and response bundle for the
// priority-queue request scheduler.
interface pq_req_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int TW   = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [2*NREQ-1:0]  req_op_i;
  logic [DW*NREQ-1:0] req_data_i;
  logic [TW*NREQ-1:0] req_id_i;
  logic               rsp_valid_o;
  logic [IW-1:0]      rsp_req_o;
  logic               rsp_err_o;
  logic [DW-1:0]      rsp_data_o;
  logic [TW-1:0]      rsp_id_o;

  modport master (
    output req_valid_i, req_op_i,
    output req_data_i, req_id_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_req_o, rsp_err_o,
    input  rsp_data_o, rsp_id_o
  );

  modport slave (
    input  req_valid_i, req_op_i,
    input  req_data_i, req_id_i,
    output req_ready_o, rsp_valid_o,
    output rsp_req_o, rsp_err_o,
    output rsp_data_o, rsp_id_o
  );
endinterface

// File: rtl/pq_req_sched.sv
// Round-robin scheduler in front of the array priority queue:
// one operation in flight, single-cycle response to its owner.
module pq_req_sched #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int TW       = 4,
  parameter int DEPTH    = 16,
  parameter int PUSH_LAT = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  pq_req_sched_if.slave                bus,
  output logic                         arr_push_o,
  output logic                         arr_pop_o,
  output logic                         arr_drop_o,
  output logic [DW-1:0]                arr_data_o,
  output logic [TW-1:0]                arr_id_o,
  input  logic                         arr_pop_vld_i,
  input  logic [DW-1:0]                arr_pop_data_i,
  input  logic [TW-1:0]                arr_pop_id_i,
  input  logic                         arr_drop_vld_i,
  input  logic                         arr_drop_hit_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int IW  = $clog2(NREQ);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WCW = $clog2(TIMEOUT + PUSH_LAT + 2);
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_PUSH,
    WAIT_POP, WAIT_DROP, RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, gnt;
  logic [1:0]     op_q, op_g;
  logic [DW-1:0]  data_q, data_g, rdata_q;
  logic [TW-1:0]  id_q, id_g, rid_q;
  logic           err_q, any_v, rej, tmo;
  logic [WCW-1:0] wcnt_q;
  logic [CW-1:0]  count_q;
  int             j;

  // Highest priority is the first valid requester after ptr_q.
  always_comb begin
    any_v = 1'b0;
    gnt   = ptr_q;
    j     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (bus.req_valid_i[IW'(j)]) begin
        any_v = 1'b1;
        gnt   = IW'(j);
      end
    end
  end

  always_comb begin
    op_g   = '0;
    data_g = '0;
    id_g   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IW'(i)) begin
        op_g   = bus.req_op_i[2*i +: 2];
        data_g = bus.req_data_i[DW*i +: DW];
        id_g   = bus.req_id_i[TW*i +: TW];
      end
    end
  end

  assign rej = (op_g == 2'b00)
             | ((op_g == OP_PUSH) & full_o)
             | (op_g[1] & empty_o);
  assign tmo = (wcnt_q == WCW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (any_v) state_d = rej ? RESP : ISSUE;
      ISSUE:
        unique case (op_q)
          OP_PUSH: state_d = WAIT_PUSH;
          OP_POP:  state_d = WAIT_POP;
          default: state_d = WAIT_DROP;
        endcase
      WAIT_PUSH:
        if (wcnt_q == WCW'(PUSH_LAT)) state_d = RESP;
      WAIT_POP:
        if (arr_pop_vld_i || tmo) state_d = RESP;
      WAIT_DROP:
        if (arr_drop_vld_i || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= IW'(NREQ - 1);
      op_q    <= '0;
      data_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rid_q   <= '0;
      wcnt_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:
          if (any_v) begin
            ptr_q   <= gnt;
            op_q    <= op_g;
            data_q  <= data_g;
            id_q    <= id_g;
            err_q   <= rej;
            rdata_q <= '0;
            rid_q   <= '0;
          end
        ISSUE:     wcnt_q <= WCW'(1);
        WAIT_PUSH: wcnt_q <= wcnt_q + WCW'(1);
        WAIT_POP: begin
          wcnt_q <= wcnt_q + WCW'(1);
          if (arr_pop_vld_i) begin
            rdata_q <= arr_pop_data_i;
            rid_q   <= arr_pop_id_i;
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        WAIT_DROP: begin
          wcnt_q <= wcnt_q + WCW'(1);
          if (arr_drop_vld_i) err_q <= ~arr_drop_hit_i;
          else if (tmo)       err_q <= 1'b1;
        end
        RESP:
          if (!err_q) begin
            count_q <= (op_q == OP_PUSH)
                     ? count_q + CW'(1)
                     : count_q - CW'(1);
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready_o = '0;
    if (state_q == IDLE && any_v)
      bus.req_ready_o = NREQ'(1) << gnt;
  end

  assign arr_push_o = (state_q == ISSUE) && (op_q == OP_PUSH);
  assign arr_pop_o  = (state_q == ISSUE) && (op_q == OP_POP);
  assign arr_drop_o = (state_q == ISSUE) && (op_q == 2'b11);
  assign arr_data_o = arr_push_o ? data_q : '0;
  assign arr_id_o   = (arr_push_o || arr_drop_o) ? id_q : '0;

  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_req_o   = bus.rsp_valid_o ? ptr_q : '0;
  assign bus.rsp_err_o   = bus.rsp_valid_o & err_q;
  assign bus.rsp_data_o  = bus.rsp_valid_o ? rdata_q : '0;
  assign bus.rsp_id_o    = bus.rsp_valid_o ? rid_q : '0;

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: tb/tb_pq_req_sched.sv
// Scoreboard bench for pq_req_sched: random commands, an emulated
// cell array and a queue-level reference model.
module tb_pq_req_sched;
  localparam int NREQ = 4, DW = 8, TW = 4;
  localparam int DEPTH = 16, PUSH_LAT = 2, TIMEOUT = 15;

  typedef struct {
    bit [1:0] op; bit [7:0] data; bit [3:0] id; int dly;
  } cmd_t;
  typedef struct {
    int cyc; int req; bit err; bit [7:0] data; bit [3:0] id; int cnt;
  } exp_t;
  typedef struct {
    int cyc; bit [1:0] op; bit [7:0] data; bit [3:0] id; int dly;
    bit [7:0] rdata; bit [3:0] rid; bit hit;
  } plan_t;
  typedef struct { bit [3:0] id; bit [7:0] data; } ent_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic arr_push, arr_pop, arr_drop;
  logic [DW-1:0] arr_data;
  logic [TW-1:0] arr_id;
  logic arr_pop_vld = 1'b0, arr_drop_vld = 1'b0, arr_drop_hit = 1'b0;
  logic [DW-1:0] arr_pop_data = '0;
  logic [TW-1:0] arr_pop_id = '0;
  logic [4:0] count;
  logic full, empty;

  int cyc = 0, nchk = 0, npass = 0;
  int rr = NREQ - 1, busy_until = -1;
  ent_t  content[$];
  exp_t  exp_q[$];
  plan_t plan_q[$];
  cmd_t  cq[NREQ][$];

  pq_req_sched_if #(.NREQ(NREQ), .DW(DW), .TW(TW)) bus ();

  pq_req_sched #(
    .NREQ(NREQ), .DW(DW), .TW(TW), .DEPTH(DEPTH),
    .PUSH_LAT(PUSH_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus),
    .arr_push_o(arr_push), .arr_pop_o(arr_pop),
    .arr_drop_o(arr_drop), .arr_data_o(arr_data),
    .arr_id_o(arr_id), .arr_pop_vld_i(arr_pop_vld),
    .arr_pop_data_i(arr_pop_data), .arr_pop_id_i(arr_pop_id),
    .arr_drop_vld_i(arr_drop_vld), .arr_drop_hit_i(arr_drop_hit),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
  endfunction

  task automatic add(int r, bit [1:0] op, bit [7:0] d, bit [3:0] id, int dly);
    cmd_t c;
    c.op = op; c.data = d; c.id = id; c.dly = dly;
    cq[r].push_back(c);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (cq[i].size() != 0) return 1'b0;
    return (exp_q.size() == 0) && (plan_q.size() == 0);
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (!all_empty() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Requester driver: hold each head command until accepted.
  initial begin : drv
    logic [NREQ-1:0] acc, v;
    logic [2*NREQ-1:0] op;
    logic [DW*NREQ-1:0] d;
    logic [TW*NREQ-1:0] id;
    bus.req_valid_i = '0; bus.req_op_i = '0;
    bus.req_data_i = '0; bus.req_id_i = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_ready_o & bus.req_valid_i & {NREQ{rst_ni}};
      @(posedge clk); #1;
      v = '0; op = '0; d = '0; id = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        if (cq[i].size() > 0) begin
          v[i] = 1'b1;
          op[2*i +: 2] = cq[i][0].op;
          d[DW*i +: DW] = cq[i][0].data;
          id[TW*i +: TW] = cq[i][0].id;
        end
      end
      bus.req_valid_i = v; bus.req_op_i = op;
      bus.req_data_i = d; bus.req_id_i = id;
    end
  end

  // Reference model: applies each accepted command atomically.
  initial begin : model
    int g, b, j;
    logic [NREQ-1:0] er;
    exp_t e; plan_t p; cmd_t c;
    bit rej, to;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        rr = NREQ - 1; busy_until = -1;
        content.delete(); exp_q.delete(); plan_q.delete();
      end else begin
        g = -1;
        if (cyc > busy_until)
          for (int k = 1; k <= NREQ; k++) begin
            j = (rr + k) % NREQ;
            if (g < 0 && ((bus.req_valid_i >> j) & 1) != 0) g = j;
          end
        er = (g < 0) ? '0 : NREQ'(1) << g;
        chk("grant", bus.req_ready_o, er);
        if (g >= 0) begin
          rr = g; c = cq[g][0];
          e.req = g; e.data = 0; e.id = 0; e.err = 0;
          rej = (c.op == 0) || (c.op == 1 && content.size() == DEPTH)
              || (c.op[1] && content.size() == 0);
          to = (c.dly == 0) || (c.dly > TIMEOUT);
          if (rej) begin
            e.err = 1; e.cyc = cyc + 1;
          end else begin
            p.cyc = cyc + 1; p.op = c.op; p.data = c.data; p.id = c.id;
            p.dly = c.dly; p.rdata = 0; p.rid = 0; p.hit = 0;
            e.cyc = to ? cyc + 2 + TIMEOUT : cyc + 2 + c.dly;
            if (c.op == 1) begin
              ent_t n; n.id = c.id; n.data = c.data;
              content.push_back(n);
              e.cyc = cyc + 2 + PUSH_LAT;
            end else if (c.op == 2) begin
              b = 0;
              foreach (content[k]) if (content[k].id > content[b].id) b = k;
              p.rdata = content[b].data; p.rid = content[b].id;
              e.err = to;
              if (!to) begin
                e.data = p.rdata; e.id = p.rid; content.delete(b);
              end
            end else begin
              b = -1;
              foreach (content[k]) if (b < 0 && content[k].id == c.id) b = k;
              p.hit = (b >= 0);
              e.err = to || !p.hit;
              if (!to && p.hit) content.delete(b);
            end
            plan_q.push_back(p);
          end
          e.cnt = content.size();
          exp_q.push_back(e);
          busy_until = e.cyc;
        end
      end
    end
  end

  // Cell-array emulator: checks pulses, answers with planned strobes.
  initial begin : arr
    plan_t p;
    forever begin
      @(negedge clk);
      if (rst_ni && (arr_push || arr_pop || arr_drop)) begin
        chk("pulse_onehot", $countones({arr_push, arr_pop, arr_drop}), 1);
        if (plan_q.size() == 0) chk("pulse_unexp", 1, 0);
        else begin
          p = plan_q.pop_front();
          chk("pulse_cyc", cyc, p.cyc);
          chk("pulse_op", {arr_drop | arr_pop, arr_drop | arr_push}, p.op);
          if (p.op == 1) chk("pulse_data", arr_data, p.data);
          if (p.op != 2) chk("pulse_id", arr_id, p.id);
          if (p.op != 1 && p.dly != 0) begin
            repeat (p.dly) @(posedge clk);
            #1;
            arr_pop_vld = (p.op == 2); arr_drop_vld = (p.op == 3);
            arr_pop_data = p.rdata; arr_pop_id = p.rid; arr_drop_hit = p.hit;
            @(posedge clk); #1;
            arr_pop_vld = 0; arr_drop_vld = 0; arr_drop_hit = 0;
            arr_pop_data = 0; arr_pop_id = 0;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin : mon
    exp_t e;
    bit pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        pend = 0;
        chk("rsp_in_rst", bus.rsp_valid_o, 0);
      end else begin
        if (pend) begin
          chk("count", count, e.cnt);
          chk("full", full, e.cnt == DEPTH);
          chk("empty", empty, e.cnt == 0);
          pend = 0;
        end
        if (bus.rsp_valid_o) begin
          if (exp_q.size() == 0) chk("rsp_unexp", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_cyc", cyc, e.cyc);
            chk("rsp_req", bus.rsp_req_o, e.req);
            chk("rsp_err", bus.rsp_err_o, e.err);
            chk("rsp_data", bus.rsp_data_o, e.data);
            chk("rsp_id", bus.rsp_id_o, e.id);
            pend = 1;
          end
        end
      end
    end
  end

  initial begin : guard
    #600000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    int r = $urandom_range(0, 99);
    c.op = (r < 5) ? 2'd0 : (r < 50) ? 2'd1 : (r < 80) ? 2'd2 : 2'd3;
    c.data = 8'($urandom);
    c.id = 4'($urandom_range(1, 15));
    r = $urandom_range(0, 9);
    c.dly = (r < 7) ? $urandom_range(1, 4) : (r == 7) ? 0
          : (r == 8) ? $urandom_range(5, 15) : 16;
    return c;
  endfunction

  initial begin : main
    int ord[5] = '{0, 1, 2, 3, 0};
    int n, id;
    cmd_t c;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rsp", bus.rsp_valid_o, 0);
    chk("rst_pulse", {arr_push, arr_pop, arr_drop}, 0);

    add(0, 1, 8'h5A, 3, 0); wait_drain();
    add(1, 1, 8'h11, 7, 0); wait_drain();
    add(2, 2, 0, 0, 2); wait_drain();
    add(3, 1, 8'h22, 2, 0); wait_drain();

    for (int r = 0; r < NREQ; r++) begin
      add(r, 1, 8'(8'h40 + r), 4'(r + 8), 0);
      add(r, 1, 8'(8'h50 + r), 4'(r + 9), 0);
    end
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (bus.req_ready_o == 0 && n < 200);
      id = -1;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready_o[i]) id = i;
      chk("rr_order", id, ord[k]);
    end
    wait_drain();

    n = content.size();
    repeat (n) add(1, 2, 0, 0, 1);
    wait_drain();
    add(1, 2, 0, 0, 1); wait_drain();
    chk("empty_cnt", count, 0);
    for (int i = 0; i < 17; i++) begin
      id = (i % 14) + 1;
      if (id >= 5) id++;
      add(i % NREQ, 1, 8'($urandom), 4'(id), 0);
    end
    wait_drain();
    chk("full_cnt", count, 16);
    chk("full_flag", full, 1);

    add(3, 3, 0, 5, 2); wait_drain();
    add(0, 3, 0, 3, 3); wait_drain();
    add(1, 2, 0, 0, 0); wait_drain();
    add(2, 2, 0, 0, 15); wait_drain();
    add(2, 2, 0, 0, 16); wait_drain();
    add(3, 3, 0, 9, 0); wait_drain();

    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < 20; k++) begin
        c = rnd_cmd();
        add($urandom_range(0, NREQ - 1), c.op, c.data, c.id, c.dly);
      end
      wait_drain();
    end

    add(0, 1, 8'h77, 6, 0); wait_drain();
    add(1, 2, 0, 0, 0);
    n = 0;
    while (cq[1].size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(posedge clk);
    #2 rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    @(posedge clk); #2 rst_ni = 1'b1;
    @(negedge clk);
    add(3, 1, 8'h33, 4, 0);
    add(0, 1, 8'h44, 5, 0);
    n = 0;
    do begin @(negedge clk); n++; end
    while (bus.req_ready_o == 0 && n < 50);
    chk("arst_first_grant", bus.req_ready_o, 4'b0001);
    wait_drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
